// File: rtl/reg_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : reg_bus_pkg
// Brief    : Shared types and defaults for the serial register bus arbiter.
// Revision : 1.0
// ============================================================================
package reg_bus_pkg;

    localparam int DEFAULT_WIDTH  = 8;
    localparam int DEFAULT_ADDR_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_t;

endpackage : reg_bus_pkg
`default_nettype wire

// File: rtl/reg_bus_clkgen.sv
`default_nettype none
// ============================================================================
// Module   : reg_bus_clkgen
// Brief    : reg_clk divider with phase strobes; runs only while enabled.
// Revision : 1.0
// ============================================================================
module reg_bus_clkgen #(
    parameter int CLK_DIV = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    input  logic i_last,
    output logic o_reg_clk,
    output logic o_phase_fall,
    output logic o_phase_end
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] c_DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] r_div;
    logic             r_high;
    logic             w_wrap;

    assign w_wrap = i_en && (r_div == c_DIV_LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_div  <= '0;
            r_high <= 1'b0;
        end else if (!i_en) begin
            r_div  <= '0;
            r_high <= 1'b0;
        end else if (w_wrap) begin
            r_div  <= '0;
            r_high <= ~r_high;
        end else begin
            r_div  <= r_div + 1'b1;
        end
    end

    // phase_fall marks the edge that opens a following low phase, so it is
    // withheld on the final bit; the first low phase is opened by the FSM.
    assign o_reg_clk    = r_high;
    assign o_phase_end  = w_wrap && r_high;
    assign o_phase_fall = w_wrap && r_high && !i_last;

endmodule : reg_bus_clkgen
`default_nettype wire

// File: rtl/reg_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : reg_bus_arbiter
// Brief    : Round-robin arbiter serialising A/B word transactions MSB-first.
// Revision : 1.0
// ============================================================================
module reg_bus_arbiter
    import reg_bus_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int ADDR_W  = DEFAULT_ADDR_W,
    parameter int CLK_DIV = 2
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_ni,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [WIDTH-1:0]  a_wdata,
    output logic              a_gnt,
    output logic              a_done,
    output logic [WIDTH-1:0]  a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [WIDTH-1:0]  b_wdata,
    output logic              b_gnt,
    output logic              b_done,
    output logic [WIDTH-1:0]  b_rdata,
    output logic              reg_clk,
    output logic              reg_dir,
    output logic [ADDR_W-1:0] reg_addr,
    output logic              reg_bus_o,
    output logic              reg_bus_oe,
    input  logic              reg_bus_i
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] c_CNT_LOAD = CNT_W'(WIDTH - 1);

    state_t            r_state;
    port_t             r_owner;
    port_t             r_last;
    logic              r_a_gnt;
    logic              r_b_gnt;
    logic              r_a_done;
    logic              r_b_done;
    logic [WIDTH-1:0]  r_a_rdata;
    logic [WIDTH-1:0]  r_b_rdata;
    logic [WIDTH-1:0]  r_shreg;
    logic              r_dir;
    logic              r_oe;
    logic [ADDR_W-1:0] r_addr;
    logic [CNT_W-1:0]  r_bit_cnt;

    logic              w_shift_en;
    logic              w_last_bit;
    logic              w_phase_fall;
    logic              w_phase_end;
    logic              w_pick_b;
    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [WIDTH-1:0]  w_sel_wdata;
    logic [WIDTH-1:0]  w_shift_in;

    assign w_shift_en  = (r_state == SHIFT);
    assign w_last_bit  = (r_bit_cnt == '0);
    // B wins only when A is silent or A was the last port served.
    assign w_pick_b    = b_req && (!a_req || (r_last == PORT_A));
    assign w_sel_we    = w_pick_b ? b_we    : a_we;
    assign w_sel_addr  = w_pick_b ? b_addr  : a_addr;
    assign w_sel_wdata = w_pick_b ? b_wdata : a_wdata;
    assign w_shift_in  = WIDTH'({r_shreg, reg_bus_i});

    reg_bus_clkgen #(
        .CLK_DIV (CLK_DIV)
    ) u_clkgen (
        .i_clk        (wb_clk_i),
        .i_rst_n      (wb_rst_ni),
        .i_en         (w_shift_en),
        .i_last       (w_last_bit),
        .o_reg_clk    (reg_clk),
        .o_phase_fall (w_phase_fall),
        .o_phase_end  (w_phase_end)
    );

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_state   <= IDLE;
            r_owner   <= PORT_A;
            r_last    <= PORT_B;
            r_a_gnt   <= 1'b0;
            r_b_gnt   <= 1'b0;
            r_a_done  <= 1'b0;
            r_b_done  <= 1'b0;
            r_a_rdata <= '0;
            r_b_rdata <= '0;
            r_shreg   <= '0;
            r_dir     <= 1'b0;
            r_oe      <= 1'b0;
            r_addr    <= '0;
            r_bit_cnt <= '0;
        end else begin
            r_a_done <= 1'b0;
            r_b_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (a_req || b_req) begin
                        r_state   <= SHIFT;
                        r_owner   <= w_pick_b ? PORT_B : PORT_A;
                        r_a_gnt   <= !w_pick_b;
                        r_b_gnt   <= w_pick_b;
                        r_dir     <= w_sel_we;
                        r_oe      <= w_sel_we;
                        r_addr    <= w_sel_addr;
                        // The MSB drives the bus from the first low phase on.
                        r_shreg   <= w_sel_we ? w_sel_wdata : '0;
                        r_bit_cnt <= c_CNT_LOAD;
                    end
                end
                SHIFT: begin
                    if (w_phase_fall && r_dir) begin
                        r_shreg <= r_shreg << 1;
                    end
                    if (w_phase_end) begin
                        if (!r_dir) begin
                            r_shreg <= w_shift_in;
                        end
                        if (w_last_bit) begin
                            r_state <= DONE;
                            r_dir   <= 1'b0;
                            r_oe    <= 1'b0;
                            r_addr  <= '0;
                            if (r_owner == PORT_B) begin
                                r_b_done <= 1'b1;
                                if (!r_dir) r_b_rdata <= w_shift_in;
                            end else begin
                                r_a_done <= 1'b1;
                                if (!r_dir) r_a_rdata <= w_shift_in;
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt - 1'b1;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_a_gnt <= 1'b0;
                    r_b_gnt <= 1'b0;
                    r_last  <= r_owner;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign a_gnt      = r_a_gnt;
    assign b_gnt      = r_b_gnt;
    assign a_done     = r_a_done;
    assign b_done     = r_b_done;
    assign a_rdata    = r_a_rdata;
    assign b_rdata    = r_b_rdata;
    assign reg_dir    = r_dir;
    assign reg_addr   = r_addr;
    assign reg_bus_oe = r_oe;
    assign reg_bus_o  = r_oe & r_shreg[WIDTH-1];

endmodule : reg_bus_arbiter
`default_nettype wire

// File: tb/tb_reg_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_bus_arbiter
// Brief    : Directed scoreboard bench for reg_bus_arbiter with a bus model.
// Revision : 1.0
// ============================================================================
module tb_reg_bus_arbiter;

    localparam int WIDTH   = 8;
    localparam int ADDR_W  = 3;
    localparam int CLK_DIV = 2;
    localparam int TXN_CYC = 2 * CLK_DIV * WIDTH + 1;

    logic              wb_clk_i = 1'b0;
    logic              wb_rst_ni = 1'b0;
    logic              a_req = 1'b0, a_we = 1'b0;
    logic [ADDR_W-1:0] a_addr = '0;
    logic [WIDTH-1:0]  a_wdata = '0;
    logic              b_req = 1'b0, b_we = 1'b0;
    logic [ADDR_W-1:0] b_addr = '0;
    logic [WIDTH-1:0]  b_wdata = '0;
    logic              reg_bus_i = 1'b0;
    logic              a_gnt, a_done, b_gnt, b_done;
    logic [WIDTH-1:0]  a_rdata, b_rdata;
    logic              reg_clk, reg_dir, reg_bus_o, reg_bus_oe;
    logic [ADDR_W-1:0] reg_addr;

    reg_bus_arbiter #(
        .WIDTH (WIDTH), .ADDR_W (ADDR_W), .CLK_DIV (CLK_DIV)
    ) dut (
        .wb_clk_i (wb_clk_i), .wb_rst_ni (wb_rst_ni),
        .a_req (a_req), .a_we (a_we), .a_addr (a_addr), .a_wdata (a_wdata),
        .a_gnt (a_gnt), .a_done (a_done), .a_rdata (a_rdata),
        .b_req (b_req), .b_we (b_we), .b_addr (b_addr), .b_wdata (b_wdata),
        .b_gnt (b_gnt), .b_done (b_done), .b_rdata (b_rdata),
        .reg_clk (reg_clk), .reg_dir (reg_dir), .reg_addr (reg_addr),
        .reg_bus_o (reg_bus_o), .reg_bus_oe (reg_bus_oe), .reg_bus_i (reg_bus_i)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    typedef struct {
        logic              port;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [WIDTH-1:0]  wdata;
        logic [WIDTH-1:0]  rdata;
    } txn_t;

    txn_t             sb[$];
    int               checks = 0;
    int               errors = 0;
    logic [WIDTH-1:0] a_model = '0;
    logic [WIDTH-1:0] b_model = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor: register-side model, per-transaction bookkeeping, scoreboard pop.
    int               pulses = 0, gcyc = 0;
    int               unstable = 0, oe_bad = 0, dir_bad = 0, addr_bad = 0, both_gnt = 0;
    logic             prev_rclk = 1'b0, prev_bo = 1'b0;
    logic [WIDTH-1:0] bits = '0;
    txn_t             cur;

    always @(negedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            pulses = 0; gcyc = 0; unstable = 0; oe_bad = 0; dir_bad = 0;
            addr_bad = 0; both_gnt = 0; prev_rclk = 1'b0; prev_bo = 1'b0;
            bits = '0; reg_bus_i = 1'b0;
        end else begin
            if (a_gnt || b_gnt) gcyc++; else gcyc = 0;
            if (a_gnt && b_gnt) both_gnt++;
            if (sb.size() > 0) begin
                cur = sb[0];
                if ((a_gnt || b_gnt) && !cur.we && reg_bus_oe) oe_bad++;
                if (reg_clk && !prev_rclk) begin
                    if (reg_bus_o !== prev_bo) unstable++;
                    if (reg_bus_oe !== cur.we) oe_bad++;
                    if (reg_dir !== cur.we) dir_bad++;
                    if (reg_addr !== cur.addr) addr_bad++;
                    if (pulses < WIDTH) reg_bus_i = cur.rdata[WIDTH-1-pulses];
                end
            end
            if (reg_clk && !prev_rclk) begin
                bits = {bits[WIDTH-2:0], reg_bus_o};
                pulses++;
            end
            if (a_done || b_done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'(a_done | b_done), 32'd0);
                end else begin
                    cur = sb.pop_front();
                    check("done_port", 32'(b_done), 32'(cur.port));
                    check("done_onehot", 32'(a_done & b_done), 32'd0);
                    check("rclk_pulses", 32'(pulses), 32'(WIDTH));
                    check("done_latency", 32'(gcyc), 32'(TXN_CYC));
                    check("bit_stable", 32'(unstable), 32'd0);
                    check("oe_level", 32'(oe_bad), 32'd0);
                    check("dir_hold", 32'(dir_bad), 32'd0);
                    check("addr_hold", 32'(addr_bad), 32'd0);
                    check("gnt_exclusive", 32'(both_gnt), 32'd0);
                    if (cur.we) check("write_bits", 32'(bits), 32'(cur.wdata));
                    else if (cur.port) b_model = cur.rdata;
                    else a_model = cur.rdata;
                    check("a_rdata", 32'(a_rdata), 32'(a_model));
                    check("b_rdata", 32'(b_rdata), 32'(b_model));
                end
                pulses = 0; unstable = 0; oe_bad = 0; dir_bad = 0;
                addr_bad = 0; both_gnt = 0; bits = '0;
            end
            prev_rclk = reg_clk;
            prev_bo   = reg_bus_o;
        end
    end

    task automatic push(input logic port, input logic we, input logic [ADDR_W-1:0] addr,
                        input logic [WIDTH-1:0] wd, input logic [WIDTH-1:0] rd);
        txn_t t;
        t.port = port; t.we = we; t.addr = addr; t.wdata = wd; t.rdata = rd;
        sb.push_back(t);
        if (port) begin b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wd; end
        else      begin a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wd; end
    endtask

    task automatic wait_done(input logic port, input string tag);
        int n = 0;
        do begin
            @(negedge wb_clk_i);
            n++;
        end while (!(port ? b_done : a_done) && n < 200);
        check(tag, 32'(port ? b_done : a_done), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        check("rst_a_gnt", 32'(a_gnt), 32'd0);
        check("rst_b_gnt", 32'(b_gnt), 32'd0);
        check("rst_done", 32'({a_done, b_done}), 32'd0);
        check("rst_a_rdata", 32'(a_rdata), 32'd0);
        check("rst_b_rdata", 32'(b_rdata), 32'd0);
        check("rst_reg_clk", 32'(reg_clk), 32'd0);
        check("rst_reg_dir", 32'(reg_dir), 32'd0);
        check("rst_reg_addr", 32'(reg_addr), 32'd0);
        check("rst_bus_o", 32'(reg_bus_o), 32'd0);
        check("rst_bus_oe", 32'(reg_bus_oe), 32'd0);
        @(posedge wb_clk_i); #1 wb_rst_ni = 1'b1;

        // Simultaneous requests out of reset: A first, then B after one idle cycle.
        @(posedge wb_clk_i); #1;
        push(1'b0, 1'b0, 3'd2, 8'h00, 8'h81);
        push(1'b1, 1'b1, 3'd5, 8'h69, 8'h00);
        wait_done(1'b0, "sim1_a_done");
        @(posedge wb_clk_i); #1 a_req = 1'b0;
        @(negedge wb_clk_i);
        check("sim1_idle_gap", 32'({a_gnt, b_gnt}), 32'd0);
        @(negedge wb_clk_i);
        check("sim1_b_gnt", 32'(b_gnt), 32'd1);
        wait_done(1'b1, "sim1_b_done");
        @(posedge wb_clk_i); #1 b_req = 1'b0;

        // Single B read of 0x3C from register 3.
        push(1'b1, 1'b0, 3'd3, 8'h00, 8'h3C);
        wait_done(1'b1, "b_read_done");
        @(posedge wb_clk_i); #1 b_req = 1'b0;

        // Single A write 0xA5 to register 1, with grant latency.
        push(1'b0, 1'b1, 3'd1, 8'hA5, 8'h00);
        @(negedge wb_clk_i);
        check("a_gnt_pre", 32'(a_gnt), 32'd0);
        @(negedge wb_clk_i);
        check("a_gnt_latency", 32'(a_gnt), 32'd1);
        wait_done(1'b0, "a_write_done");
        @(posedge wb_clk_i); #1 a_req = 1'b0;

        // Both again with A served last: B first, then A.
        push(1'b1, 1'b0, 3'd4, 8'h00, 8'hC3);
        push(1'b0, 1'b1, 3'd7, 8'h0F, 8'h00);
        wait_done(1'b1, "sim2_b_done");
        @(posedge wb_clk_i); #1 b_req = 1'b0;
        @(negedge wb_clk_i);
        check("sim2_idle_gap", 32'({a_gnt, b_gnt}), 32'd0);
        @(negedge wb_clk_i);
        check("sim2_a_gnt", 32'(a_gnt), 32'd1);
        wait_done(1'b0, "sim2_a_done");
        @(posedge wb_clk_i); #1 a_req = 1'b0;

        // Withdrawal: A drops req and scrambles operands mid-SHIFT.
        push(1'b0, 1'b1, 3'd6, 8'h5A, 8'h00);
        @(posedge wb_clk_i);
        repeat (10) @(posedge wb_clk_i);
        #1 a_req = 1'b0; a_wdata = 8'hFF; a_addr = 3'd0; a_we = 1'b0;
        wait_done(1'b0, "withdraw_done");
        @(negedge wb_clk_i);
        @(negedge wb_clk_i);
        check("withdraw_no_restart", 32'(a_gnt), 32'd0);

        // Asynchronous reset in the high phase of bit 4.
        @(posedge wb_clk_i); #1;
        push(1'b0, 1'b1, 3'd2, 8'hE7, 8'h00);
        @(posedge wb_clk_i);
        repeat (18) @(posedge wb_clk_i);
        #2;
        check("midrst_pre_rclk", 32'(reg_clk), 32'd1);
        wb_rst_ni = 1'b0;
        a_req = 1'b0;
        #1;
        check("midrst_reg_clk", 32'(reg_clk), 32'd0);
        check("midrst_bus_oe", 32'(reg_bus_oe), 32'd0);
        check("midrst_a_gnt", 32'(a_gnt), 32'd0);
        check("midrst_done", 32'({a_done, b_done}), 32'd0);
        check("midrst_b_rdata", 32'(b_rdata), 32'd0);
        sb.delete();
        a_model = '0;
        b_model = '0;
        repeat (4) @(negedge wb_clk_i);
        @(posedge wb_clk_i); #1 wb_rst_ni = 1'b1;

        // Fresh A write after reset release.
        @(posedge wb_clk_i); #1;
        push(1'b0, 1'b1, 3'd1, 8'h96, 8'h00);
        wait_done(1'b0, "post_rst_done");
        @(posedge wb_clk_i); #1 a_req = 1'b0;
        repeat (3) @(posedge wb_clk_i);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_reg_bus_arbiter
`default_nettype wire
